// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - chained valid/ready register slices with one-entry skid buffers, flush and stall
// Optional feature macro: PIPE_OCC_COUNT_EN (adds the registered occupancy output)

module pipe_skid_stage #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_OCC_COUNT_EN
    ,
    output logic [$clog2(2*DEPTH+1)-1:0] occupancy
`endif
);

    // Per-slice state: main holds the older entry, skid the younger one.
    logic [DEPTH-1:0] main_valid;
    logic [DEPTH-1:0] skid_valid;
    logic [WIDTH-1:0] main_data [DEPTH];
    logic [WIDTH-1:0] skid_data [DEPTH];

    // Handshakes into (up_xfer) and out of (dn_xfer) each slice this cycle.
    logic [DEPTH-1:0] up_xfer;
    logic [DEPTH-1:0] dn_xfer;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             dn_ready;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_link
            assign up_valid = main_valid[k-1];
            assign up_data  = main_data[k-1];
        end

        // A slice's ready is its registered !skid_valid, so out_ready never
        // reaches in_ready combinationally.
        if (k == DEPTH - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_inner
            assign dn_ready = !skid_valid[k+1];
        end

        // Stall gates every handshake, which freezes the whole chain.
        assign up_xfer[k] = up_valid && !skid_valid[k] && !stall;
        assign dn_xfer[k] = main_valid[k] && dn_ready && !stall;

        // Slice state machine: EMPTY / FULL1 (main only) / FULL2 (main + skid).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_valid[k] <= 1'b0;
                skid_valid[k] <= 1'b0;
                main_data[k]  <= RESET_VAL;
                skid_data[k]  <= RESET_VAL;
            end else if (flush) begin
                main_valid[k] <= 1'b0;
                skid_valid[k] <= 1'b0;
                main_data[k]  <= RESET_VAL;
                skid_data[k]  <= RESET_VAL;
            end else if (dn_xfer[k]) begin
                if (skid_valid[k]) begin
                    // FULL2 -> FULL1: skid entry advances into main.
                    main_data[k]  <= skid_data[k];
                    skid_valid[k] <= 1'b0;
                end else if (up_xfer[k]) begin
                    // FULL1 with pass-through: main is replaced.
                    main_data[k] <= up_data;
                end else begin
                    // FULL1 -> EMPTY: data is kept, only valid drops.
                    main_valid[k] <= 1'b0;
                end
            end else if (up_xfer[k]) begin
                if (main_valid[k]) begin
                    // FULL1 -> FULL2: downstream is blocked, park in skid.
                    skid_data[k]  <= up_data;
                    skid_valid[k] <= 1'b1;
                end else begin
                    // EMPTY -> FULL1.
                    main_data[k]  <= up_data;
                    main_valid[k] <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = !skid_valid[0] && !stall;
    assign out_valid = main_valid[DEPTH-1] && !stall;
    assign out_data  = main_data[DEPTH-1];

`ifdef PIPE_OCC_COUNT_EN
    localparam int OCC_W = $clog2(2*DEPTH+1);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Entry counter: a flush-cycle input is discarded, so flush wins outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_fire && !out_fire) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (out_fire && !in_fire) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - self-checking bench for pipe_skid_stage: vector table, corner sequences, random scoreboard

module tb_pipe_skid_stage;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 2;
    localparam logic [7:0] RV    = 8'd3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             stall;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef PIPE_OCC_COUNT_EN
    logic [$clog2(2*DEPTH+1)-1:0] occupancy;
`endif

    pipe_skid_stage #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_OCC_COUNT_EN
        ,
        .occupancy (occupancy)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_occ(input string name, input int exp);
`ifdef PIPE_OCC_COUNT_EN
        chk(name, int'(occupancy), exp);
`else
        if (exp < 0) $display("unused %s", name);
`endif
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       st;
        logic       fl;
        logic       eov;
        logic [7:0] eod;
        logic       chk_d;
        logic       eir;
    } vec_t;

    vec_t vecs[12];

    task automatic idle_flush();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Offer base, base+1, ... with out_ready low until n beats are accepted.
    task automatic push_n(input int n, input int base, output int acc);
        acc = 0;
        for (int c = 0; c < 4 * n + 4 && acc < n; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'(base + acc); out_ready = 1'b0;
            #1;
            if (in_ready) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    int q[$];
    int nxt, acc, got, gaps, cnt;
    logic hold;

    initial begin
        rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state, while held and after release.
        @(negedge clk); #1;
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_od", int'(out_data), int'(RV));
        chk("rst_ir", int'(in_ready), 1);
        chk_occ("rst_occ", 0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rel_ov", int'(out_valid), 0);
        chk("rel_od", int'(out_data), int'(RV));
        chk("rel_ir", int'(in_ready), 1);

        // Vector table: inputs applied for one cycle, outputs checked before the edge.
        vecs[0]  = '{1'b1, 8'd86, 1'b1, 1'b0, 1'b0, 1'b0, RV,    1'b1, 1'b1};
        vecs[1]  = '{1'b1, 8'd5,  1'b1, 1'b0, 1'b0, 1'b0, RV,    1'b1, 1'b1};
        vecs[2]  = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 8'd86, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 8'd5,  1'b1, 1'b1};
        vecs[4]  = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1};
        vecs[5]  = '{1'b1, 8'd7,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'd7,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1};
        vecs[7]  = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1};
        vecs[9]  = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'd7,  1'b1, 1'b1};
        vecs[10] = '{1'b1, 8'd9,  1'b0, 1'b0, 1'b1, 1'b1, 8'd7,  1'b1, 1'b1};
        vecs[11] = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, RV,    1'b1, 1'b1};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
            stall = vecs[i].st; flush = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d_ov", i), int'(out_valid), int'(vecs[i].eov));
            chk($sformatf("vec%0d_ir", i), int'(in_ready), int'(vecs[i].eir));
            if (vecs[i].chk_d) chk($sformatf("vec%0d_od", i), int'(out_data), int'(vecs[i].eod));
        end

        // Capacity: 2*DEPTH beats accepted with out_ready low, then drain in order.
        idle_flush();
        nxt = 1; acc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            in_valid = (nxt <= 6); in_data = 8'(nxt); out_ready = 1'b0;
            #1;
            if (in_valid && in_ready) begin nxt++; acc++; end
        end
        chk("cap_accepted", acc, 2 * DEPTH);
        chk("cap_ir_low", int'(in_ready), 0);
        chk_occ("cap_occ", 2 * DEPTH);
        got = 0; gaps = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = (nxt <= 6); in_data = 8'(nxt);
            #1;
            if (in_valid && in_ready) nxt++;
            if (out_valid) begin
                chk("cap_order", int'(out_data), got + 1);
                got++;
            end else if (got > 0 && got < 6) gaps++;
        end
        chk("cap_got", got, 6);
        chk("cap_gaps", gaps, 0);
        chk("cap_all_in", nxt, 7);

        // Stall with three entries held: nothing moves, contents survive.
        idle_flush();
        push_n(3, 11, acc);
        chk("stl_fill", acc, 3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            stall = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'd77;
            #1;
            chk("stl_ov", int'(out_valid), 0);
            chk("stl_ir", int'(in_ready), 0);
            chk_occ("stl_occ", 3);
        end
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid) begin
                chk("stl_order", int'(out_data), 11 + got);
                got++;
            end
        end
        chk("stl_got", got, 3);

        // Flush with two entries held and an offered beat that must be dropped.
        idle_flush();
        push_n(2, 21, acc);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'd99; out_ready = 1'b0;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_ov", int'(out_valid), 0);
        chk("fl_od", int'(out_data), int'(RV));
        chk("fl_ir", int'(in_ready), 1);
        chk_occ("fl_occ", 0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (out_valid) cnt++;
        end
        chk("fl_no_ghost", cnt, 0);

        // Asynchronous reset between edges with data held.
        idle_flush();
        push_n(2, 31, acc);
        @(negedge clk); #1;
        chk("ar_pre_ov", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ov", int'(out_valid), 0);
        chk("ar_od", int'(out_data), int'(RV));
        chk("ar_ir", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against an ordered-queue scoreboard.
        q.delete();
        hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            #1;
            if (stall) begin
                chk("rnd_stall_ir", int'(in_ready), 0);
                chk("rnd_stall_ov", int'(out_valid), 0);
            end
            if (q.size() == 0) chk("rnd_empty_ov", int'(out_valid), 0);
            else if (out_valid) chk("rnd_data", int'(out_data), q[0]);
            if (!stall && q.size() == 0) chk("rnd_empty_ir", int'(in_ready), 1);
            if (q.size() == 2 * DEPTH) chk("rnd_full_ir", int'(in_ready), 0);
            chk_occ("rnd_occ", q.size());
            if (flush) q.delete();
            else begin
                if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
                if (in_valid && in_ready) q.push_back(int'(in_data));
            end
            hold = in_valid && !in_ready && !flush;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
